rks_loader: RTL
===============

Name: rks_loader

Overview:
- Sequencer that turns an RKS tape-image byte stream from the ARM I/O download channel into CPU-RAM writes.
- Parses the 4-byte header (start, end), writes the payload to RAM through a request/acknowledge port, and verifies the trailing 16-bit checksum.
- Holds the CPU in reset while loading, then presents the entry address.
- Sits between mist_io (download index 1) and the sram arbitration path.

Parameters:
- FIFO_DEPTH, 4: input byte FIFO depth; power of two, at least 2.
- ADDR_W, 16: CPU address width used for the header fields and for mem_addr.

Ports:
- clk_sys  in  1  system clock (96 MHz).
- reset_n  in  1  asynchronous, active-low reset.
- dl_active  in  1  download of an RKS image in progress (ioctl_download & index==1).
- dl_wr  in  1  one-cycle byte strobe.
- dl_data  in  8  byte accompanying dl_wr.
- mem_req  out  1  write request; held until mem_ack.
- mem_addr  out  ADDR_W  write address.
- mem_dout  out  8  write data.
- mem_ack  in  1  one-cycle pulse: write complete.
- busy  out  1  load in progress; used as CPU reset/hold.
- done  out  1  one-cycle pulse at the end of a load (good or bad).
- err  out  2  0 = OK, 1 = checksum, 2 = range (end < start), 3 = truncated.
- start_addr  out  ADDR_W  parsed start address; the CPU entry point.

Behaviour:
- Reset values: mem_req=0, mem_addr=0, mem_dout=0, busy=0, done=0, err=0, start_addr=0. FIFO is empty and the FSM is in IDLE.
- Input FIFO:
  - dl_wr pushes dl_data.
  - A pop occurs when the FSM consumes a byte.
  - A push and a pop in the same cycle are both honoured.
  - A push while full is dropped and sets a sticky overflow, reported as err=3 at completion.
- dl_active rising edge (registered edge detect):
  - From any state: flush FIFO, clear checksum, err and byte counters, set busy=1, enter HDR.
  - A rising edge mid-load restarts the load; any mem_req in flight is dropped without waiting for its ack, and a stale ack is ignored.
- HDR: consume 4 bytes in order start_lo, start_hi, end_lo, end_hi; start_addr updates when start_hi is taken.
  - After end_hi, if end < start: set err=2 and go to SKIP.
  - Otherwise len = end − start + 1, held in 17 bits (start=0, end=0xFFFF gives 65536). Set the write index to 0 and go to DATA.
- DATA, when the FIFO is not empty and mem_req=0:
  - Pop a byte, then drive mem_addr = start + idx (mod 2^ADDR_W), mem_dout = byte, mem_req=1 on the next cycle.
  - On mem_ack: mem_req=0 and idx+1. When idx reaches len, go to CSUM.
  - At most one outstanding write. Latency from pop to mem_req is 1 clock.
- Checksum (16-bit, updated on each payload byte b):
  - For every byte except the last: cs = cs + {b, b} (b added to both halves, mod 2^16).
  - For the last byte: cs = cs + b (low half only, with carry into the high half).
- CSUM: consume cs_hi, then cs_lo; compare with the computed cs and set err=1 on mismatch. Then go to SKIP.
- SKIP: discard any further bytes.
- dl_active falling edge:
  - In HDR, DATA (with or without an outstanding write) or CSUM: wait for an outstanding ack if any, then set err=3.
  - In all cases: FIFO flushed, done pulses 1 cycle, busy→0 in the same cycle, FSM to IDLE.
  - err and start_addr hold until the next load starts.
- IDLE: dl_wr bytes are ignored (no push).

Decomposition:
- Shared package specialist_pkg:
  - enum for FSM states IDLE/HDR/DATA/CSUM/SKIP.
  - enum for err codes ERR_OK/ERR_CSUM/ERR_RANGE/ERR_TRUNC.
  - RKS header length constant (4) and trailer length constant (2).
- One natural sub-module: byte_fifo (parameterised depth; push/pop/full/empty/flush). It is reusable by the FDD path.

Test Plan:
- Image 00 40 02 40 AA 55 CC cs_hi cs_lo with the correct checksum (computed by the reference model) → writes 0x4000=AA, 0x4001=55, 0x4002=CC in order. On dl_active fall: done=1 for one cycle, err=0, start_addr=0x4000, busy 1→0.
- Same image with a corrupted cs_lo → same three writes, err=1.
- Header start=0x4010, end=0x4000 → zero mem_req, err=2 at the fall of dl_active.
- dl_active drops after 2 of 3 payload bytes, with ack delayed 20 clocks on the second write → the FSM waits for that ack, then err=3 and done pulses.
- mem_ack stalled 50 clocks while 6 bytes arrive back-to-back with FIFO_DEPTH=4 → overflow reported as err=3; with ack at 1 clock, no loss and err=0.
- Mid-DATA: reset_n low → all outputs return to reset values immediately, no further writes. Also check a second dl_active rising edge mid-load: the load restarts, new start_addr is used, old data is not resumed.

Source files
------------

// File: rtl/specialist_pkg.sv
// Shared types and constants for the RKS tape-image loader and its byte FIFO.
package specialist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DATA,
    CSUM,
    SKIP
  } state_t;

  typedef enum logic [1:0] {
    ERR_OK    = 2'd0,
    ERR_CSUM  = 2'd1,
    ERR_RANGE = 2'd2,
    ERR_TRUNC = 2'd3
  } err_t;

  localparam int RKS_HDR_LEN = 4;
  localparam int RKS_TRL_LEN = 2;

  // The last payload byte only enters the low half; all others enter both halves.
  function automatic logic [15:0] cs_step(input logic [15:0] cs, input logic [7:0] b,
                                          input logic last);
    return last ? cs + {8'h00, b} : cs + {b, b};
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Small synchronous byte FIFO with flush; a push while full is dropped and flagged on drop.
module byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty,
  output logic       drop
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty && !flush;
  // A slot freed by a same-cycle pop can take the incoming byte.
  assign do_push = push && !flush && (!full || do_pop);
  assign drop    = push && !flush && !do_push;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/rks_loader.sv
// Turns an RKS tape-image download stream into CPU RAM writes, holding the CPU in reset
// while loading and reporting header, checksum and truncation errors at completion.
module rks_loader
  import specialist_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 16
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              dl_active,
  input  logic              dl_wr,
  input  logic [7:0]        dl_data,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_dout,
  input  logic              mem_ack,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err,
  output logic [ADDR_W-1:0] start_addr
);

  state_t      state;
  logic        act_q;
  logic        draining;
  logic        ovf;
  logic [1:0]  cnt;
  logic [7:0]  lo_byte;
  logic [7:0]  cs_hi;
  logic [15:0] start_f;
  logic [16:0] len;
  logic [16:0] idx;
  logic [15:0] cs;

  logic        rise;
  logic        fall;
  logic        finish;
  logic        pop;
  logic        push;
  logic        flush;
  logic [7:0]  fifo_dout;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_drop;
  logic [15:0] end_f;
  logic        last_byte;

  assign rise      = dl_active && !act_q;
  assign fall      = !dl_active && act_q;
  // The load ends on the fall, or later once the write that was in flight is acknowledged.
  assign finish    = (state != IDLE) && !rise && (fall || draining) && (!mem_req || mem_ack);
  assign push      = dl_wr && (state != IDLE);
  assign flush     = rise || finish;
  assign pop       = !rise && !fall && !draining && !fifo_empty &&
                     ((state == HDR) || (state == CSUM) || (state == SKIP) ||
                      ((state == DATA) && !mem_req));
  assign end_f     = {fifo_dout, lo_byte};
  assign last_byte = ((idx + 17'd1) == len);

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk_sys),
    .rst_n (reset_n),
    .flush (flush),
    .push  (push),
    .din   (dl_data),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .drop  (fifo_drop)
  );

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      act_q      <= 1'b0;
      draining   <= 1'b0;
      ovf        <= 1'b0;
      cnt        <= '0;
      lo_byte    <= '0;
      cs_hi      <= '0;
      start_f    <= '0;
      len        <= '0;
      idx        <= '0;
      cs         <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      mem_dout   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= ERR_OK;
      start_addr <= '0;
    end else begin
      act_q <= dl_active;
      done  <= 1'b0;
      if (fifo_drop) ovf <= 1'b1;

      if (rise) begin
        // Restart from any state; an in-flight write is abandoned, not awaited.
        state    <= HDR;
        busy     <= 1'b1;
        err      <= ERR_OK;
        cs       <= '0;
        cnt      <= '0;
        idx      <= '0;
        ovf      <= 1'b0;
        draining <= 1'b0;
        mem_req  <= 1'b0;
      end else if (finish) begin
        state    <= IDLE;
        busy     <= 1'b0;
        done     <= 1'b1;
        mem_req  <= 1'b0;
        draining <= 1'b0;
        if ((state inside {HDR, DATA, CSUM}) || ovf || fifo_drop) err <= ERR_TRUNC;
      end else if (fall) begin
        draining <= 1'b1;
      end else if (!draining) begin
        case (state)
          HDR: begin
            if (pop) begin
              cnt <= cnt + 1'b1;
              case (cnt)
                2'd0: lo_byte <= fifo_dout;
                2'd1: begin
                  start_f    <= {fifo_dout, lo_byte};
                  start_addr <= ADDR_W'({fifo_dout, lo_byte});
                end
                2'd2: lo_byte <= fifo_dout;
                default: begin
                  if (end_f < start_f) begin
                    err   <= ERR_RANGE;
                    state <= SKIP;
                  end else begin
                    len   <= {1'b0, end_f} - {1'b0, start_f} + 17'd1;
                    idx   <= '0;
                    state <= DATA;
                  end
                end
              endcase
            end
          end
          DATA: begin
            if (mem_req) begin
              if (mem_ack) begin
                mem_req <= 1'b0;
                idx     <= idx + 17'd1;
                if (last_byte) begin
                  state <= CSUM;
                  cnt   <= '0;
                end
              end
            end else if (pop) begin
              mem_req  <= 1'b1;
              mem_addr <= start_addr + ADDR_W'(idx);
              mem_dout <= fifo_dout;
              cs       <= cs_step(cs, fifo_dout, last_byte);
            end
          end
          CSUM: begin
            if (pop) begin
              cnt <= cnt + 1'b1;
              if (cnt == 2'(RKS_TRL_LEN - 1)) begin
                if ({cs_hi, fifo_dout} != cs) err <= ERR_CSUM;
                state <= SKIP;
              end else begin
                cs_hi <= fifo_dout;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
